// File: rtl/psum_requant_drain.sv
// psum_requant_drain
//
// Output stage of a PE_A column. It accumulates cfg_passes partial sums per
// output pixel, then requantises the group sum: round half up, arithmetic
// right shift, optional ReLU, and saturation to an activation. Results go
// into a small FIFO with a valid/ready output. Back-pressure from that FIFO
// reaches the PE column through in_ready.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   clear           synchronous abort of the current group plus FIFO flush
//   in_valid        inPartialSum carries data
//   in_ready        input is accepted this cycle
//   inPartialSum    signed partial sum from the last PE of the column
//   cfg_passes      passes per group (0 behaves as 1), latched per group
//   cfg_shift       right shift applied before saturation, latched per group
//   cfg_relu        1 = ReLU + unsigned saturation, 0 = signed saturation
//   out_valid       FIFO head holds a result
//   out_ready       consumer takes the head
//   out_activation  requantised activation (FIFO head register)
//   groups_done     results written into the FIFO, wraps at 2^16
module psum_requant_drain #(
    parameter int accumulationPar = 21,
    parameter int activationPar   = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [accumulationPar-1:0] inPartialSum,
    input  logic [3:0]                 cfg_passes,
    input  logic [4:0]                 cfg_shift,
    input  logic                       cfg_relu,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [activationPar-1:0]   out_activation,
    output logic [15:0]                groups_done
);

    localparam int ACC_W    = accumulationPar + 4;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;
    localparam int RELU_MAX = (1 << activationPar) - 1;
    localparam int SGN_MAX  = (1 << (activationPar - 1)) - 1;
    localparam int SGN_MIN  = -(1 << (activationPar - 1));

    // Group state
    logic signed [ACC_W-1:0] acc_reg;
    logic [3:0]              pass_cnt_reg;
    logic [3:0]              passes_reg;
    logic [4:0]              shift_reg;
    logic                    relu_reg;

    // Result FIFO
    logic [activationPar-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_reg;
    logic [AW-1:0]            rd_ptr_reg;
    logic [CW-1:0]            count_reg;
    logic [activationPar-1:0] head_reg;
    logic [15:0]              groups_done_reg;

    // Datapath
    logic                     accept;
    logic                     first_pass;
    logic                     last_pass;
    logic                     push;
    logic                     pop;
    logic [3:0]               cfg_passes_eff;
    logic [3:0]               eff_passes;
    logic [4:0]               eff_shift;
    logic                     eff_relu;
    logic signed [ACC_W-1:0]  in_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [31:0]       sum_wide;
    logic signed [31:0]       round_bias;
    logic signed [31:0]       shifted;
    logic [activationPar-1:0] sat;
    logic [CW-1:0]            count_next;
    logic [AW-1:0]            rd_ptr_next;
    logic [activationPar-1:0] head_next;

    assign in_ready       = !clear && (count_reg < CW'(FIFO_DEPTH));
    assign accept         = in_valid && in_ready;
    assign out_valid      = (count_reg != '0);
    assign out_activation = head_reg;
    assign groups_done    = groups_done_reg;

    always_comb begin
        cfg_passes_eff = (cfg_passes == 4'd0) ? 4'd1 : cfg_passes;
        first_pass     = (pass_cnt_reg == 4'd0);
        // The first input of a group uses the live configuration, because
        // that is the same edge on which it gets latched.
        eff_passes     = first_pass ? cfg_passes_eff : passes_reg;
        eff_shift      = first_pass ? cfg_shift      : shift_reg;
        eff_relu       = first_pass ? cfg_relu       : relu_reg;
        last_pass      = (pass_cnt_reg == eff_passes - 4'd1);

        in_ext   = {{(ACC_W - accumulationPar){inPartialSum[accumulationPar-1]}}, inPartialSum};
        sum      = first_pass ? in_ext : acc_reg + in_ext;

        // Widen to 32 bits so that the rounding bias (up to 2^30 for the
        // largest shift code) cannot overflow the group sum.
        sum_wide   = 32'(sum);
        round_bias = (eff_shift == 5'd0) ? 32'sd0 : (32'sd1 <<< (eff_shift - 5'd1));
        shifted    = (sum_wide + round_bias) >>> eff_shift;

        sat = shifted[activationPar-1:0];
        if (eff_relu) begin
            if (shifted < 32'sd0)
                sat = '0;
            else if (shifted > RELU_MAX)
                sat = activationPar'(RELU_MAX);
        end else begin
            if (shifted < SGN_MIN)
                sat = activationPar'(SGN_MIN);
            else if (shifted > SGN_MAX)
                sat = activationPar'(SGN_MAX);
        end
    end

    always_comb begin
        push = accept && last_pass;
        pop  = out_valid && out_ready;

        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + CW'(1);
        else if (pop && !push)
            count_next = count_reg - CW'(1);

        rd_ptr_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

        // The head register is loaded from the entry that becomes the head.
        // When that entry is the one being written on this edge, it is not
        // in the array yet, so it is taken straight from the datapath.
        if (push && (count_next == CW'(1)))
            head_next = sat;
        else
            head_next = mem[rd_ptr_next];
    end

    // Storage array: no reset, because the pointers and count decide what
    // is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= sat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg         <= '0;
            pass_cnt_reg    <= '0;
            passes_reg      <= 4'd1;
            shift_reg       <= '0;
            relu_reg        <= 1'b0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            head_reg        <= '0;
            groups_done_reg <= '0;
        end else if (clear) begin
            // Abort the group and flush the FIFO. The head register keeps its
            // last value, and the result counter is left alone.
            acc_reg      <= '0;
            pass_cnt_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            if (accept) begin
                if (first_pass) begin
                    passes_reg <= cfg_passes_eff;
                    shift_reg  <= cfg_shift;
                    relu_reg   <= cfg_relu;
                end
                acc_reg      <= sum;
                pass_cnt_reg <= last_pass ? 4'd0 : pass_cnt_reg + 4'd1;
            end
            if (push) begin
                wr_ptr_reg      <= wr_ptr_reg + AW'(1);
                groups_done_reg <= groups_done_reg + 16'd1;
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (count_next != '0)
                head_reg <= head_next;
        end
    end

endmodule

// File: tb/tb_psum_requant_drain.sv
// Directed bench for psum_requant_drain. A queue-based model of the group
// arithmetic and the result FIFO is checked against the DUT on every falling
// edge. Each scenario then compares the values the DUT handed out against
// hand-computed literals.
module tb_psum_requant_drain;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [20:0] inPartialSum = '0;
    logic [3:0]  cfg_passes = 4'd1;
    logic [4:0]  cfg_shift = '0;
    logic        cfg_relu = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_activation;
    logic [15:0] groups_done;

    int tests = 0;
    int fails = 0;

    // Model state
    int     mq[$];
    int     got_q[$];
    int     m_pass = 0;
    int     m_passes = 1;
    int     m_shift = 0;
    bit     m_relu = 0;
    longint m_acc = 0;
    int     m_groups = 0;
    int     m_last = 0;

    psum_requant_drain dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .inPartialSum(inPartialSum),
        .cfg_passes(cfg_passes),
        .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_activation(out_activation),
        .groups_done(groups_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Floor-division reference: round half up, then clamp, then return the
    // 8-bit code.
    function automatic int requant(input longint sum, input int s, input bit relu);
        longint d, num, q;
        if (s == 0) begin
            q = sum;
        end else begin
            d   = longint'(1) << s;
            num = sum + d / 2;
            q   = num / d;
            if ((num % d != 0) && (num < 0))
                q = q - 1;
        end
        if (relu) begin
            if (q < 0) q = 0;
            if (q > 255) q = 255;
        end else begin
            if (q < -128) q = -128;
            if (q > 127) q = 127;
        end
        return int'(q) & 255;
    endfunction

    // Compare, then advance the model to the state after the next rising edge.
    always @(negedge clk) begin : model
        int x;
        bit acc_ok;
        bit pop;
        if (rst) begin
            mq.delete();
            m_pass = 0; m_acc = 0; m_groups = 0; m_last = 0;
            m_passes = 1; m_shift = 0; m_relu = 0;
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_groups_done", int'(groups_done), 0);
            chk("rst_out_activation", int'(out_activation), 0);
        end else begin
            chk("in_ready", int'(in_ready), int'(!clear && mq.size() < DEPTH));
            chk("out_valid", int'(out_valid), int'(mq.size() > 0));
            chk("out_activation", int'(out_activation), m_last);
            chk("groups_done", int'(groups_done), m_groups & 16'hFFFF);
            if (out_valid && out_ready)
                got_q.push_back(int'(out_activation));
            x = int'($signed(inPartialSum));
            if (clear) begin
                mq.delete();
                m_pass = 0;
                m_acc = 0;
            end else begin
                acc_ok = in_valid && (mq.size() < DEPTH);
                pop    = out_ready && (mq.size() > 0);
                if (pop)
                    void'(mq.pop_front());
                if (acc_ok) begin
                    if (m_pass == 0) begin
                        m_passes = (cfg_passes == 0) ? 1 : int'(cfg_passes);
                        m_shift  = int'(cfg_shift);
                        m_relu   = cfg_relu;
                        m_acc    = x;
                    end else begin
                        m_acc = m_acc + x;
                    end
                    if (m_pass == m_passes - 1) begin
                        mq.push_back(requant(m_acc, m_shift, m_relu));
                        m_pass = 0;
                        m_groups++;
                    end else begin
                        m_pass++;
                    end
                end
            end
            if (mq.size() > 0)
                m_last = mq[0];
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds one partial sum until it is accepted. Called at posedge+1 and
    // returns at posedge+1.
    task automatic send(input int x);
        int n;
        bit taken;
        n = 0;
        taken = 0;
        in_valid = 1'b1;
        inPartialSum = 21'(x);
        while (!taken && n < 60) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!taken) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic set_cfg(input int p, input int s, input bit r);
        cfg_passes = 4'(p);
        cfg_shift  = 5'(s);
        cfg_relu   = r;
    endtask

    task automatic expect_list(input string name, input int exp[$]);
        chk({name, "_count"}, got_q.size(), exp.size());
        foreach (exp[i])
            chk($sformatf("%s[%0d]", name, i), (i < got_q.size()) ? got_q[i] : -1, exp[i]);
        got_q.delete();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish, expected finish within 100000 time units");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int ex[$];

        // These pin the reference function itself.
        chk("pin_requant_a", requant(-15728640, 16, 0), 128);
        chk("pin_requant_b", requant(-300, 2, 1), 0);
        chk("pin_requant_c", requant(250, 1, 1), 125);

        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_groups", int'(groups_done), 0);
        idle(1);

        // Three passes, ReLU, shift 1.
        out_ready = 1'b1;
        set_cfg(3, 1, 1);
        send(100); send(200); send(-50);
        idle(3);
        ex = {125};
        expect_list("s1", ex);
        chk("s1_groups", int'(groups_done), 1);

        // Single pass, ReLU, shift 2: rounding, upper clamp, lower clamp.
        set_cfg(1, 2, 1);
        send(1000); send(2000); send(-300);
        idle(3);
        ex = {250, 255, 0};
        expect_list("s2", ex);

        // Signed saturation, then the largest-magnitude 15-pass group.
        set_cfg(1, 0, 0);
        send(-300); send(127); send(-1048576);
        idle(3);
        set_cfg(15, 16, 0);
        for (int i = 0; i < 15; i++) send(-1048576);
        idle(3);
        ex = {8'h80, 8'h7F, 8'h80, 8'h80};
        expect_list("s3", ex);

        // Back-pressure: only DEPTH results fit, and the head holds.
        out_ready = 1'b0;
        set_cfg(1, 0, 0);
        fork
            begin
                for (int i = 1; i <= 6; i++) send(i);
            end
            begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                chk("full_in_ready", int'(in_ready), 0);
                chk("full_head", int'(out_activation), 1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(8);
        ex = {1, 2, 3, 4, 5, 6};
        expect_list("s4", ex);

        // Clear mid-group drops the input offered with it. A cfg_passes
        // change mid-group only applies from the next group.
        set_cfg(4, 0, 0);
        send(10); send(20);
        in_valid = 1'b1;
        inPartialSum = 21'(999);
        clear = 1'b1;
        @(negedge clk);
        chk("clear_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        send(1); send(2);
        cfg_passes = 4'd2;
        send(3); send(4);
        send(5); send(6);
        idle(3);
        ex = {10, 11};
        expect_list("s5", ex);

        // Asynchronous reset with results queued and a group half done.
        out_ready = 1'b0;
        set_cfg(1, 0, 0);
        send(7); send(8);
        set_cfg(3, 0, 0);
        send(1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_groups", int'(groups_done), 0);
        idle(2);
        rst = 1'b0;
        out_ready = 1'b1;
        set_cfg(2, 0, 0);
        send(3); send(4);
        idle(3);
        ex = {7};
        expect_list("s6", ex);
        chk("s6_groups", int'(groups_done), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
